mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Multicycle memory front-end between the main control FSM and the unified instruction/data memory.
- Accepts one read or write request at a time and holds address and write data stable for the memory's fixed latency.
- Captures read data into the instruction register (IR) or the memory data register (MDR), then pulses done back to the control FSM.
- Replaces the control FSM's fixed fetch delay states with a handshake; exposes decoded IR fields (op, funct, rs, rt, rd, imm, jump target) to control and datapath.

Parameters:
- READ_LATENCY, 2, cycles from address presentation to valid mem_rdata; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the IR field slicing requires 32.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- req_valid  in  1  control requests a memory access.
- req_wr  in  1  1 = write, 0 = read.
- req_ir  in  1  read destination: 1 = IR, 0 = MDR; ignored on writes.
- req_addr  in  ADDR_W  byte address, from PC or ALUOut.
- req_wdata  in  DATA_W  store data, from B.
- req_ready  out  1  sequencer idle and able to accept.
- done  out  1  one-cycle pulse; access complete.
- busy  out  1  access in progress, i.e. not IDLE.
- mem_addr  out  ADDR_W  address to memory.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  data to memory.
- mem_rdata  in  DATA_W  data from memory.
- ir_out  out  32  instruction register.
- mdr_out  out  DATA_W  memory data register.
- op_out  out  6  ir_out[31:26].
- funct_out  out  6  ir_out[5:0].
- rs_out, rt_out, rd_out  out  5 each  ir_out[25:21], [20:16], [15:11].
- imm_out  out  16  ir_out[15:0].
- jtarget_out  out  26  ir_out[25:0].

Behaviour:
- FSM states: IDLE, ACCESS, DONE. req_ready=1 only in IDLE; busy = !req_ready.
- Reset (Reset=0 sampled at a rising edge):
  - State goes to IDLE; latched addr, wdata and flags cleared; counter cleared.
  - ir_out and mdr_out set to 0, so op_out=0 and funct_out=0.
  - done=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access aborts the access: no capture, no done, and mem_wr is low from the next cycle on.
- Accept: at edge E0 with state IDLE and req_valid=1:
  - Latch req_addr, req_wr, req_ir and req_wdata.
  - Go to ACCESS; load counter with READ_LATENCY-1.
- mem_addr and mem_wdata are registered copies of the latched values; they stay stable from E0 until the return to IDLE.
- Write path:
  - mem_wr=1 for exactly the one cycle following E0.
  - At E1 go to DONE; done=1 in the cycle after E1.
  - At E2 return to IDLE.
- Read path:
  - mem_wr stays 0.
  - At each edge in ACCESS: if counter is not 0, decrement it; if counter is 0, sample mem_rdata, write it to ir_out (req_ir=1) or mdr_out (req_ir=0), and go to DONE.
  - The capture edge is E_READ_LATENCY.
  - done=1 and the new register value are visible together in the cycle after that edge.
  - Next edge returns to IDLE. Total occupancy is READ_LATENCY+2 cycles.
- ir_out changes only on an IR-destined read capture; mdr_out only on an MDR-destined read capture. The non-targeted register holds its value.
- Decoded field outputs are pure slices of ir_out (zero latency from ir_out).
- req_valid while busy: ignored. No queueing, no error. Control must hold or re-issue the request after done.
- req_valid high in the DONE cycle: not accepted. It is accepted at the first edge seen in IDLE, so back-to-back accesses have one bubble minimum.
- Request inputs are not sampled outside the accept edge; changes during ACCESS have no effect.
- done is never asserted for two consecutive cycles.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with req_valid=1 -> ir_out=0, mdr_out=0, done=0, mem_wr=0, req_ready=1 after release.
- IR fetch with READ_LATENCY=2: req_addr=0x00000040, req_ir=1, memory returns 0x8C220004 two cycles after the address -> done in the 3rd cycle after accept; ir_out=0x8C220004, op_out=0x23, rs_out=1, rt_out=2, imm_out=0x0004; mdr_out unchanged.
- Store: req_wr=1, req_addr=0x100, req_wdata=0xDEADBEEF -> mem_wr high for exactly one cycle with mem_addr=0x100 and mem_wdata=0xDEADBEEF; done one cycle later; ir_out and mdr_out unchanged.
- Busy rejection: a second req_valid (addr=0x200) raised during ACCESS of a read from 0x80 -> mem_addr stays 0x80 throughout; exactly one done; the second request is accepted only in the following IDLE cycle.
- Reset mid-read: Reset=0 at the edge after accept -> no done pulse, ir_out=0, state IDLE, req_ready=1 the next cycle.
- Latency sweep READ_LATENCY=1 and 4: MDR read returns 0x00000123 -> done exactly READ_LATENCY+1 cycles after the accept edge, mdr_out=0x00000123, ir_out unchanged.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Multicycle memory front-end that sits between the main control FSM and the
// unified instruction/data memory. One read or write is accepted at a time.
// Address and write data are held stable while the access is in flight. Read
// data is captured into the instruction register (IR) or the memory data
// register (MDR). A one-cycle done pulse is then returned to the control FSM.
// The decoded IR fields are exposed as zero-latency slices of ir_out.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        synchronous, active-low reset
//   req_valid    control requests a memory access
//   req_wr       1 = write, 0 = read
//   req_ir       read destination: 1 = IR, 0 = MDR (ignored on writes)
//   req_addr     byte address (PC or ALUOut)
//   req_wdata    store data (B register)
//   req_ready    idle and able to accept a request
//   done         one-cycle pulse, access complete
//   busy         access in progress (not idle)
//   mem_addr     address to memory, stable for the whole access
//   mem_wr       memory write strobe, one cycle per write
//   mem_wdata    data to memory, stable for the whole access
//   mem_rdata    data from memory, valid READ_LATENCY cycles after address
//   ir_out       instruction register
//   mdr_out      memory data register
//   op_out, funct_out, rs_out, rt_out, rd_out, imm_out, jtarget_out
//                instruction fields sliced from ir_out
//
// Parameters
//   READ_LATENCY  cycles from address presentation to valid read data (1..15)
//   ADDR_W        address width
//   DATA_W        data width (the IR field slicing requires 32)
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
   parameter int READ_LATENCY = 2,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic              req_ir,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       ir_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic [5:0]        op_out,
   output logic [5:0]        funct_out,
   output logic [4:0]        rs_out,
   output logic [4:0]        rt_out,
   output logic [4:0]        rd_out,
   output logic [15:0]       imm_out,
   output logic [25:0]       jtarget_out
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   // The counter runs READ_LATENCY-1 down to 0; the capture happens on the
   // edge where it is already 0, which makes that edge E_READ_LATENCY.
   localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              capture;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic              ir_sel_q;
   logic [3:0]        cnt_q;
   logic [31:0]       ir_q;
   logic [DATA_W-1:0] mdr_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // Writes complete after the single strobe cycle; reads wait out
            // the memory latency and capture on the final edge.
            if (wr_q) begin
               state_nxt = DONE;
            end else if (cnt_q == 4'd0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter and destination registers. The request
   // inputs are only looked at on the accept edge.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         ir_sel_q <= 1'b0;
         cnt_q    <= '0;
         ir_q     <= '0;
         mdr_q    <= '0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wr_q     <= req_wr;
            ir_sel_q <= req_ir;
            cnt_q    <= CNT_LOAD;
         end else if (state == ACCESS && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (capture) begin
            if (ir_sel_q) begin
               ir_q <= mem_rdata[31:0];
            end else begin
               mdr_q <= mem_rdata;
            end
         end
      end
   end

   // Handshake and strobe are decoded from registered state, so they are
   // glitch-free and done and the captured value appear in the same cycle.
   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;
   assign done      = (state == DONE);
   assign mem_wr    = (state == ACCESS) && wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign ir_out      = ir_q;
   assign mdr_out     = mdr_q;
   assign op_out      = ir_q[31:26];
   assign funct_out   = ir_q[5:0];
   assign rs_out      = ir_q[25:21];
   assign rt_out      = ir_q[20:16];
   assign rd_out      = ir_q[15:11];
   assign imm_out     = ir_q[15:0];
   assign jtarget_out = ir_q[25:0];

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Three sequencers with READ_LATENCY 1, 2 and 4 are driven one after another
// by a cycle-accurate driver. The memory model presents valid read data only
// in the cycle before the edge on which a correct capture occurs. In every
// other cycle it drives the inverted word or a random word. IR/MDR contents
// are predicted from the request stream alone.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

   localparam int N_DUT = 3;

   logic        clk;
   logic        rst_n       [N_DUT];
   logic        req_valid   [N_DUT];
   logic        req_wr      [N_DUT];
   logic        req_ir      [N_DUT];
   logic [31:0] req_addr    [N_DUT];
   logic [31:0] req_wdata   [N_DUT];
   logic        req_ready   [N_DUT];
   logic        done        [N_DUT];
   logic        busy        [N_DUT];
   logic [31:0] mem_addr    [N_DUT];
   logic        mem_wr      [N_DUT];
   logic [31:0] mem_wdata   [N_DUT];
   logic [31:0] mem_rdata   [N_DUT];
   logic [31:0] ir_out      [N_DUT];
   logic [31:0] mdr_out     [N_DUT];
   logic [5:0]  op_out      [N_DUT];
   logic [5:0]  funct_out   [N_DUT];
   logic [4:0]  rs_out      [N_DUT];
   logic [4:0]  rt_out      [N_DUT];
   logic [4:0]  rd_out      [N_DUT];
   logic [15:0] imm_out     [N_DUT];
   logic [25:0] jtarget_out [N_DUT];

   // Reference model state: expected register contents per instance.
   logic [31:0] exp_ir  [N_DUT];
   logic [31:0] exp_mdr [N_DUT];

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      mem_access_sequencer #(
         .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
         .ADDR_W      (32),
         .DATA_W      (32)
      ) u_dut (
         .Clk        (clk),
         .Reset      (rst_n[g]),
         .req_valid  (req_valid[g]),
         .req_wr     (req_wr[g]),
         .req_ir     (req_ir[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .req_ready  (req_ready[g]),
         .done       (done[g]),
         .busy       (busy[g]),
         .mem_addr   (mem_addr[g]),
         .mem_wr     (mem_wr[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_rdata  (mem_rdata[g]),
         .ir_out     (ir_out[g]),
         .mdr_out    (mdr_out[g]),
         .op_out     (op_out[g]),
         .funct_out  (funct_out[g]),
         .rs_out     (rs_out[g]),
         .rt_out     (rt_out[g]),
         .rd_out     (rd_out[g]),
         .imm_out    (imm_out[g]),
         .jtarget_out(jtarget_out[g])
      );
   end

   function automatic int lat_of(input int idx);
      return (idx == 0) ? 1 : ((idx == 1) ? 2 : 4);
   endfunction

   function automatic string tg(input int idx, input string name);
      return $sformatf("L%0d.%s", lat_of(idx), name);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_regs(input int idx, input string where);
      logic [31:0] e;
      e = exp_ir[idx];
      check(tg(idx, {where, ".ir"}),    ir_out[idx],                 e);
      check(tg(idx, {where, ".mdr"}),   mdr_out[idx],                exp_mdr[idx]);
      check(tg(idx, {where, ".op"}),    32'(op_out[idx]),            32'(e >> 26));
      check(tg(idx, {where, ".funct"}), 32'(funct_out[idx]),         e & 32'h3F);
      check(tg(idx, {where, ".rsrtrd"}),
            {17'd0, rs_out[idx], rt_out[idx], rd_out[idx]},          (e >> 11) & 32'h7FFF);
      check(tg(idx, {where, ".imm"}),   32'(imm_out[idx]),           e & 32'hFFFF);
      check(tg(idx, {where, ".jtgt"}),  32'(jtarget_out[idx]),       e & 32'h03FF_FFFF);
   endtask

   // Entered and left just after a negedge in an idle cycle. With poke set,
   // a second request is raised during the access and held into the
   // following idle cycle, where the next call takes it over.
   task automatic do_access(input int idx, input bit wr, input bit ir,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input bit poke);
      int lat;
      int n_acc;
      lat   = lat_of(idx);
      n_acc = wr ? 1 : lat;
      check(tg(idx, "idle.ready"), req_ready[idx], 1);
      check(tg(idx, "idle.busy"),  busy[idx],      0);
      req_valid[idx] = 1'b1;
      req_wr[idx]    = wr;
      req_ir[idx]    = ir;
      req_addr[idx]  = addr;
      req_wdata[idx] = wdata;
      @(negedge clk);
      // Request inputs change freely during the access; they must be ignored.
      req_valid[idx] = poke;
      req_wr[idx]    = 1'($urandom);
      req_ir[idx]    = 1'($urandom);
      req_addr[idx]  = poke ? 32'h200 : $urandom;
      req_wdata[idx] = $urandom;
      for (int k = 1; k <= n_acc; k++) begin
         mem_rdata[idx] = (!wr && k == lat) ? rdata : ~rdata;
         check(tg(idx, "acc.addr"),  mem_addr[idx],  addr);
         check(tg(idx, "acc.wdata"), mem_wdata[idx], wdata);
         check(tg(idx, "acc.wr"),    mem_wr[idx],    32'(wr));
         check(tg(idx, "acc.done"),  done[idx],      0);
         check(tg(idx, "acc.ready"), req_ready[idx], 0);
         check(tg(idx, "acc.busy"),  busy[idx],      1);
         @(negedge clk);
      end
      mem_rdata[idx] = $urandom;
      if (!wr) begin
         if (ir) exp_ir[idx]  = rdata;
         else    exp_mdr[idx] = rdata;
      end
      check(tg(idx, "done.done"),  done[idx],      1);
      check(tg(idx, "done.wr"),    mem_wr[idx],    0);
      check(tg(idx, "done.ready"), req_ready[idx], 0);
      check(tg(idx, "done.busy"),  busy[idx],      1);
      check(tg(idx, "done.addr"),  mem_addr[idx],  addr);
      check_regs(idx, "done");
      if (!poke) req_valid[idx] = 1'b0;
      @(negedge clk);
      check(tg(idx, "post.done"),  done[idx],      0);
      check(tg(idx, "post.ready"), req_ready[idx], 1);
      check(tg(idx, "post.wr"),    mem_wr[idx],    0);
   endtask

   task automatic idle(input int idx, input int n);
      req_valid[idx] = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check(tg(idx, "gap.ready"), req_ready[idx], 1);
         check(tg(idx, "gap.done"),  done[idx],      0);
      end
   endtask

   // A read is accepted, then Reset is sampled low on the very next edge.
   // Read data is valid at that edge, so an L=1 capture would otherwise occur.
   task automatic reset_mid(input int idx, input logic [31:0] addr, input logic [31:0] rdata);
      req_valid[idx] = 1'b1;
      req_wr[idx]    = 1'b0;
      req_ir[idx]    = 1'b1;
      req_addr[idx]  = addr;
      mem_rdata[idx] = rdata;
      @(negedge clk);
      rst_n[idx]     = 1'b0;
      req_valid[idx] = 1'b0;
      @(negedge clk);
      exp_ir[idx]  = '0;
      exp_mdr[idx] = '0;
      check(tg(idx, "rmid.done"),  done[idx],      0);
      check(tg(idx, "rmid.wr"),    mem_wr[idx],    0);
      check(tg(idx, "rmid.ready"), req_ready[idx], 1);
      check(tg(idx, "rmid.addr"),  mem_addr[idx],  0);
      check_regs(idx, "rmid");
      rst_n[idx] = 1'b1;
      @(negedge clk);
      check(tg(idx, "rmid2.done"),  done[idx],      0);
      check(tg(idx, "rmid2.ready"), req_ready[idx], 1);
      check(tg(idx, "rmid2.ir"),    ir_out[idx],    0);
   endtask

   task automatic run_suite(input int idx);
      bit          wr;
      bit          ir;
      bit          poke;
      logic [31:0] addr;

      // IR fetch: lw $2, 4($1).
      do_access(idx, 1'b0, 1'b1, 32'h40, 32'h0, 32'h8C22_0004, 1'b0);
      check(tg(idx, "fetch.op"),  32'(op_out[idx]),  32'h23);
      check(tg(idx, "fetch.rs"),  32'(rs_out[idx]),  32'd1);
      check(tg(idx, "fetch.rt"),  32'(rt_out[idx]),  32'd2);
      check(tg(idx, "fetch.imm"), 32'(imm_out[idx]), 32'h4);

      // Store.
      do_access(idx, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);

      // Read from 0x80 while a second request (0x200) is held high.
      do_access(idx, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 1'b1);
      do_access(idx, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0000_0123, 1'b0);
      check(tg(idx, "mdr123"), mdr_out[idx], 32'h0000_0123);
      check(tg(idx, "ir.kept"), ir_out[idx], 32'h8C22_0004);

      reset_mid(idx, 32'h44, 32'h1234_5678);

      for (int n = 0; n < 40; n++) begin
         wr   = ($urandom_range(0, 2) == 0);
         ir   = 1'($urandom);
         poke = ($urandom_range(0, 3) == 0);
         addr = $urandom & 32'hFFFF_FFFC;
         do_access(idx, wr, ir, addr, $urandom, $urandom, poke);
         if (!poke) idle(idx, $urandom_range(0, 2));
      end
      idle(idx, 1);
   endtask

   initial begin
      for (int i = 0; i < N_DUT; i++) begin
         rst_n[i]     = 1'b0;
         req_valid[i] = 1'b1;
         req_wr[i]    = 1'b0;
         req_ir[i]    = 1'b1;
         req_addr[i]  = 32'h40;
         req_wdata[i] = 32'h5555_5555;
         mem_rdata[i] = 32'hFFFF_FFFF;
         exp_ir[i]    = '0;
         exp_mdr[i]   = '0;
      end
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) begin
            check(tg(i, "rst.ready"), req_ready[i], 1);
            check(tg(i, "rst.done"),  done[i],      0);
            check(tg(i, "rst.wr"),    mem_wr[i],    0);
         end
      end
      for (int i = 0; i < N_DUT; i++) begin
         rst_n[i]     = 1'b1;
         req_valid[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         check(tg(i, "rel.ready"), req_ready[i], 1);
         check(tg(i, "rel.busy"),  busy[i],      0);
         check(tg(i, "rel.done"),  done[i],      0);
         check(tg(i, "rel.wr"),    mem_wr[i],    0);
         check(tg(i, "rel.addr"),  mem_addr[i],  0);
         check(tg(i, "rel.wdata"), mem_wdata[i], 0);
         check_regs(i, "rel");
      end

      for (int i = 0; i < N_DUT; i++) run_suite(i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
